// File: rtl/aes_isbyte_arb.sv
// aes_isbyte_arb: round-robin front end that shares one 4-lane inverse S-box between two requesters.
// Optional feature: define AES_ISBYTE_ZEROIZE_EN to wipe the state registers after each response.
module aes_isbyte_arb #(
  parameter int Nb = 4  // state columns; only 4 is supported
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [4*Nb-1:0][7:0] req0_state,
  input  logic [4*Nb-1:0][7:0] req1_state,
  output logic [3:0][7:0]      lk_idx,
  input  logic [3:0][7:0]      lk_val,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*Nb-1:0][7:0] rsp_state,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [1:0]           col;
  logic                 last_grant;
  logic                 id_q;
  logic [4*Nb-1:0][7:0] in_q;
  logic [4*Nb-1:0][7:0] res_q;
  logic                 grant0;
  logic                 grant1;

  // Byte position of row `row` in column `c` (index = row*Nb + column).
  function automatic logic [3:0] byte_sel(input int row, input logic [1:0] c);
    return 4'(row * Nb + int'(c));
  endfunction

  // Ties go to whichever requester was not granted last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_id     = id_q;

  always_comb begin
    lk_idx = '0;
    if (state == BUSY) begin
      for (int i = 0; i < 4; i++) lk_idx[i] = in_q[byte_sel(i, col)];
    end
  end

`ifdef AES_ISBYTE_ZEROIZE_EN
  assign rsp_state = (state == DONE) ? res_q : '0;
`else
  assign rsp_state = res_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the state registers are reset too, so an aborted operation leaves no key-dependent residue.
      state      <= IDLE;
      col        <= '0;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      in_q       <= '0;
      res_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            in_q       <= grant1 ? req1_state : req0_state;
            id_q       <= grant1;
            last_grant <= grant1;
            col        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < 4; i++) res_q[byte_sel(i, col)] <= lk_val[i];
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
`ifdef AES_ISBYTE_ZEROIZE_EN
            in_q  <= '0;
            res_q <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_isbyte_arb.sv
// tb_aes_isbyte_arb: directed and random checks of aes_isbyte_arb against a cycle-level transaction model.
// The inverse S-box is computed from GF(2^8) arithmetic and serves both as lookup responder and reference.
module tb_aes_isbyte_arb;
  localparam int Nb = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0][7:0]     req0_state, req1_state, rsp_state;
  logic [3:0][7:0]      lk_idx, lk_val;
  logic                 rsp_valid, rsp_ready, rsp_id, busy;

  always #5 clk = ~clk;

  aes_isbyte_arb #(.Nb(Nb)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_state(req0_state), .req1_state(req1_state),
    .lk_idx(lk_idx), .lk_val(lk_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_state(rsp_state), .busy(busy)
  );

  logic [7:0] inv_sbox [256];
  for (genvar g = 0; g < 4; g++) begin : g_lk
    assign lk_val[g] = inv_sbox[lk_idx[g]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] x, t;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      inv_sbox[v] = 8'h00;
      for (int y = 1; y < 256; y++)
        if (t != 8'h00 && gmul(t, 8'(y)) == 8'h01) inv_sbox[v] = 8'(y);
    end
  endtask

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  // Transaction model: stage 0 idle, 1..4 lookup cycles, 5 response pending.
  int               m_stage;
  logic             m_last, m_id;
  logic [15:0][7:0] m_in, m_res;

  int               cyc;
  logic             last_rv, last_r0, last_r1, last_busy, last_id;
  logic [15:0][7:0] last_rs;

  task automatic model_reset();
    m_stage = 0; m_last = 1'b1; m_id = 1'b0; m_in = '0; m_res = '0;
  endtask

  task automatic step();
    logic             g0, g1;
    logic [3:0][7:0]  exp_lk;
    logic [15:0][7:0] idle_rs;
    #1;
    g0 = (m_stage == 0) && req0_valid && (!req1_valid || m_last);
    g1 = (m_stage == 0) && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", 128'(req0_ready), 128'(g0));
    check("req1_ready", 128'(req1_ready), 128'(g1));
    check("busy", 128'(busy), 128'(m_stage != 0));
    check("rsp_valid", 128'(rsp_valid), 128'(m_stage == 5));
    exp_lk = '0;
    if (m_stage >= 1 && m_stage <= 4)
      for (int i = 0; i < 4; i++) exp_lk[i] = m_in[i*Nb + m_stage - 1];
    check("lk_idx", 128'(lk_idx), 128'(exp_lk));
    if (m_stage == 5) begin
      check("rsp_id", 128'(rsp_id), 128'(m_id));
      check("rsp_state", 128'(rsp_state), 128'(m_res));
    end else if (m_stage == 0) begin
`ifdef AES_ISBYTE_ZEROIZE_EN
      idle_rs = '0;
`else
      idle_rs = m_res;
`endif
      check("idle_rsp_state", 128'(rsp_state), 128'(idle_rs));
    end
    last_rv = rsp_valid; last_r0 = req0_ready; last_r1 = req1_ready;
    last_busy = busy; last_id = rsp_id; last_rs = rsp_state;
    cyc++;
    if (rst) model_reset();
    else if (m_stage == 0) begin
      if (g0 || g1) begin
        m_id = g1; m_last = g1;
        m_in = g1 ? req1_state : req0_state;
        for (int b = 0; b < 16; b++) m_res[b] = inv_sbox[m_in[b]];
        m_stage = 1;
      end
    end else if (m_stage < 5) m_stage++;
    else if (rsp_ready) begin
      m_stage = 0;
`ifdef AES_ISBYTE_ZEROIZE_EN
      m_in = '0; m_res = '0;
`endif
    end
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin step(); lat++; end while (!last_rv && lat < 20);
  endtask

  function automatic logic [15:0][7:0] rand_state();
    logic [15:0][7:0] s;
    for (int b = 0; b < 16; b++) s[b] = 8'($urandom_range(255));
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat, cyc_a;
    logic             seen;
    logic [15:0][7:0] rs_hold;
    logic             id_hold;

    build_sbox();
    cyc = 0;
    rst = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_state = '0; req1_state = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;

    // All-zero state from req0: response at T+5, all bytes 0x52.
    req0_state = {16{8'h00}}; req0_valid = 1; rsp_ready = 1;
    step();
    check("hs_r0", 128'(last_r0), 128'(1));
    req0_valid = 0;
    wait_rsp(lat);
    check("latency", 128'(lat), 128'(5));
    check("zero_rsp", 128'(last_rs), 128'({16{8'h52}}));
    check("zero_id", 128'(last_id), 128'(0));
    step();
`ifdef AES_ISBYTE_ZEROIZE_EN
    check("post_rsp_state", 128'(last_rs), 128'(0));
`else
    check("post_rsp_state", 128'(last_rs), 128'({16{8'h52}}));
`endif

    // Simultaneous requests after reset: req0 first, req1 six cycles later; req1 held off while busy.
    rst = 1; step(); rst = 0;
    req0_state = {16{8'h63}}; req1_state = {16{8'h7c}};
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    step();
    check("tie_r0", 128'(last_r0), 128'(1));
    check("tie_r1", 128'(last_r1), 128'(0));
    req0_valid = 0;
    seen = 0;
    lat = 0;
    do begin step(); lat++; seen |= last_r1; end while (!last_rv && lat < 20);
    check("r1_held_off", 128'(seen), 128'(0));
    check("first_rsp", 128'(last_rs), 128'({16{8'h00}}));
    check("first_id", 128'(last_id), 128'(0));
    cyc_a = cyc;
    step();
    check("r1_grant", 128'(last_r1), 128'(1));
    req1_valid = 0;
    wait_rsp(lat);
    check("second_gap", 128'(cyc - cyc_a), 128'(6));
    check("second_rsp", 128'(last_rs), 128'({16{8'h01}}));
    check("second_id", 128'(last_id), 128'(1));
    step();

    // Backpressure in DONE: response holds for 10 cycles, no new grant.
    req0_state = rand_state(); req0_valid = 1; rsp_ready = 0;
    step();
    req1_state = rand_state(); req1_valid = 1;
    wait_rsp(lat);
    rs_hold = last_rs; id_hold = last_id;
    repeat (10) begin
      step();
      check("hold_valid", 128'(last_rv), 128'(1));
      check("hold_state", 128'(last_rs), 128'(rs_hold));
      check("hold_id", 128'(last_id), 128'(id_hold));
      check("hold_nogrant", 128'(last_r0 | last_r1), 128'(0));
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    step();
    step();

    // Reset at col=2 aborts with no response and cleared result.
    req0_state = rand_state(); req0_valid = 1; rsp_ready = 1;
    step();
    req0_valid = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    step();
    check("abort_busy", 128'(last_busy), 128'(0));
    check("abort_state", 128'(last_rs), 128'(0));
    seen = 0;
    repeat (10) begin step(); seen |= last_rv; end
    check("abort_no_rsp", 128'(seen), 128'(0));

    // Random traffic against the model.
    repeat (500) begin
      req0_valid = 1'($urandom_range(1));
      req1_valid = 1'($urandom_range(1));
      req0_state = rand_state();
      req1_state = rand_state();
      rsp_ready  = ($urandom_range(3) != 0);
      rst        = ($urandom_range(99) == 0);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_isbyte_arb.md
AES_ISBYTE_ARB -- requirements
Module: aes_isbyte_arb

Interface
REQ-001 The block SHALL take parameter Nb, default 4 (from aes_const), meaning state columns; only Nb=4 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, requester n offers a state.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each, requester n's state is accepted this cycle.
REQ-006 The block SHALL have ports req0_state/req1_state, input, [7:0] x 16 (index i*Nb+j, row i, column j), each requester's input state.
REQ-007 The block SHALL have port lk_idx, output, [7:0] x 4, the byte-lane indices to the shared inverse S-box lookup.
REQ-008 The block SHALL have port lk_val, input, [7:0] x 4, the lookup results, combinational in the same cycle as lk_idx.
REQ-009 The block SHALL have port rsp_valid, output, 1, a result is available.
REQ-010 The block SHALL have port rsp_ready, input, 1, the consumer accepts the result.
REQ-011 The block SHALL have port rsp_id, output, 1, the requester that owns the result.
REQ-012 The block SHALL have port rsp_state, output, [7:0] x 16, the substituted state.
REQ-013 The block SHALL have port busy, output, 1, high when not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, plus a 2-bit column counter col.
REQ-015 In IDLE, reqN_ready SHALL equal the grant to N; a handshake (valid&ready) SHALL register the state and id, clear col and go to BUSY.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; when only one is valid, grant it; last_grant SHALL update only on a handshake.
REQ-017 Both ready outputs SHALL be 0 in BUSY and DONE.
REQ-018 In BUSY, lk_idx[i] SHALL equal the stored byte [i*Nb+col]; the result byte [i*Nb+col] SHALL be written with lk_val[i]; col SHALL increment each cycle.
REQ-019 BUSY SHALL last exactly 4 cycles (col 0..3); after col=3 the FSM SHALL go to DONE.
REQ-020 rsp_valid SHALL be high exactly in DONE; with the handshake in cycle T, rsp_valid SHALL first be high in cycle T+5.
REQ-021 In DONE, rsp_state and rsp_id SHALL hold stable while rsp_ready is 0.
REQ-022 rsp_valid&rsp_ready SHALL return the FSM to IDLE the next cycle; no request SHALL be accepted in that handshake cycle.
REQ-023 Outside BUSY, lk_idx SHALL be 0.
REQ-024 Throughput SHALL be at most one state per 6 cycles with rsp_ready held high.

Reset
REQ-025 rst SHALL force: IDLE, col=0, last_grant=1 (req0 wins first), rsp_valid=0, rsp_id=0, rsp_state all 0, busy=0, readies follow IDLE grant.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation with no response and clear the result registers on the next edge.

Configuration
REQ-027 With macro AES_ISBYTE_ZEROIZE_EN defined, the input and result state registers SHALL be cleared to 0 in the cycle after the response handshake, and rsp_state SHALL read 0 while not in DONE.
REQ-028 Without AES_ISBYTE_ZEROIZE_EN, the registers SHALL retain their last contents after the response; rsp_state SHALL show the result register in all states.

Verification
REQ-029 The bench SHALL cover: real inverse S-box; req0_state all 0x00, rsp_ready=1 -> rsp_valid at T+5, rsp_id=0, all bytes 0x52.
REQ-030 The bench SHALL cover: req0 and req1 valid together after reset (req0 bytes 0x63, req1 bytes 0x7c) -> req0 granted first (result all 0x00); req1 result all 0x01, with rsp_id=1, 6 cycles later.
REQ-031 The bench SHALL cover: req1 valid while BUSY -> req1_ready stays 0 until IDLE.
REQ-032 The bench SHALL cover: rsp_ready held 0 for 10 cycles in DONE -> rsp_state/rsp_id stable, rsp_valid stays 1, no new grant.
REQ-033 The bench SHALL cover: rst pulsed at col=2 -> next cycle IDLE, busy=0, rsp_valid never asserts, rsp_state=0.
REQ-034 The bench SHALL cover: with AES_ISBYTE_ZEROIZE_EN, after the response handshake -> rsp_state reads 0 the next cycle; without the macro -> it keeps the last result.
